// File: rtl/serial_burst_slave.sv
// Bit-serial bus slave with an on-chip word memory, optional burst header and a done/err response.
// Optional per-beat even parity is enabled by defining SERIAL_SLAVE_PARITY_EN.
module serial_burst_slave #(
  parameter int N         = 8,
  parameter int ADN       = 12,
  parameter int MEM_DEPTH = 2048,
  parameter int BN        = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid_in,
  input  logic wren,
  input  logic burst_en,
  input  logic addr_in,
  input  logic data_in,
  input  logic ready_in,
  output logic ready,
  output logic valid_out,
  output logic data_out,
  output logic done,
  output logic err
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int BW = N + 1;
`else
  localparam int BW = N;
`endif
  localparam int MAXB = (ADN > BW) ? ((ADN > BN) ? ADN : BN) : ((BW > BN) ? BW : BN);
  localparam int CW   = $clog2(MAXB + 1);
  localparam int AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADN - 1);
  localparam logic [CW-1:0] BLEN_LAST = CW'(BN - 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BW - 1);
  localparam logic [ADN:0]  DEPTH_W   = (ADN + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_BLEN, S_WDATA, S_WCOMMIT, S_RFETCH, S_RDATA, S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_live;
  logic            r_wren;
  logic            r_burst;
  logic            r_err;
  logic [ADN-1:0]  r_addr;
  logic [BN-1:0]   r_len;
  logic [BN-1:0]   r_beat;
  logic [CW-1:0]   r_bitcnt;
  logic [BW-1:0]   r_shift;
  logic [N-1:0]    r_mem [0:MEM_DEPTH-1];

  logic            w_in_range;
  logic            w_par_ok;
  logic            w_beat_last;
  logic            w_wr_en;
  logic [AW-1:0]   w_idx;
  logic [N-1:0]    w_wdata;
  logic [N-1:0]    w_rd_word;
  logic [BW-1:0]   w_fetch;

  assign w_in_range  = ({1'b0, r_addr} < DEPTH_W);
  assign w_idx       = r_addr[AW-1:0];
  assign w_beat_last = (r_beat == r_len);
  assign w_wdata     = r_shift[BW-1 -: N];
  assign w_rd_word   = w_in_range ? r_mem[w_idx] : '0;
`ifdef SERIAL_SLAVE_PARITY_EN
  assign w_par_ok = ~(^r_shift);
  assign w_fetch  = {w_rd_word, ^w_rd_word};
`else
  assign w_par_ok = 1'b1;
  assign w_fetch  = w_rd_word;
`endif
  assign w_wr_en = (r_state == S_WCOMMIT) && w_in_range && w_par_ok;

  // r_live holds ready low until the first clock edge after reset release.
  assign ready     = r_live && ((r_state == S_IDLE) || (r_state == S_ADDR) ||
                                (r_state == S_BLEN) || (r_state == S_WDATA));
  assign valid_out = (r_state == S_RDATA);
  assign data_out  = (r_state == S_RDATA) && r_shift[BW-1];
  assign done      = (r_state == S_RESP);
  assign err       = (r_state == S_RESP) && r_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (valid_in && r_live) w_state_next = S_ADDR;
      S_ADDR:    if (valid_in && r_bitcnt == ADDR_LAST) begin
                   if (r_burst)     w_state_next = S_BLEN;
                   else if (r_wren) w_state_next = S_WDATA;
                   else             w_state_next = S_RFETCH;
                 end
      S_BLEN:    if (valid_in && r_bitcnt == BLEN_LAST) w_state_next = r_wren ? S_WDATA : S_RFETCH;
      S_WDATA:   if (valid_in && r_bitcnt == BEAT_LAST) w_state_next = S_WCOMMIT;
      S_WCOMMIT: w_state_next = w_beat_last ? S_RESP : S_WDATA;
      S_RFETCH:  w_state_next = S_RDATA;
      S_RDATA:   if (ready_in && r_bitcnt == BEAT_LAST) w_state_next = w_beat_last ? S_RESP : S_RFETCH;
      S_RESP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live   <= 1'b0;
      r_wren   <= 1'b0;
      r_burst  <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: if (valid_in && r_live) begin
          r_wren   <= wren;
          r_burst  <= burst_en;
          r_addr   <= ADN'(addr_in);
          r_len    <= '0;
          r_beat   <= '0;
          r_err    <= 1'b0;
          r_bitcnt <= CW'(1);
        end
        S_ADDR: if (valid_in) begin
          r_addr   <= ADN'({r_addr, addr_in});
          r_bitcnt <= (r_bitcnt == ADDR_LAST) ? '0 : r_bitcnt + 1'b1;
        end
        S_BLEN: if (valid_in) begin
          r_len    <= BN'({r_len, addr_in});
          r_bitcnt <= (r_bitcnt == BLEN_LAST) ? '0 : r_bitcnt + 1'b1;
        end
        S_WDATA: if (valid_in) begin
          r_shift  <= {r_shift[BW-2:0], data_in};
          r_bitcnt <= (r_bitcnt == BEAT_LAST) ? '0 : r_bitcnt + 1'b1;
        end
        S_WCOMMIT: begin
          if (!(w_in_range && w_par_ok)) r_err <= 1'b1;
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat + 1'b1;
        end
        S_RFETCH: begin
          r_shift <= w_fetch;
          if (!w_in_range) r_err <= 1'b1;
          r_addr <= r_addr + 1'b1;
        end
        S_RDATA: if (ready_in) begin
          r_shift <= {r_shift[BW-2:0], 1'b0};
          if (r_bitcnt == BEAT_LAST) begin
            r_bitcnt <= '0;
            r_beat   <= r_beat + 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_serial_burst_slave.sv
// Directed self-checking bench for serial_burst_slave: a 2048-word and a 4096-word instance share stimulus.
module tb_serial_burst_slave;
  localparam int N   = 8;
  localparam int ADN = 12;
  localparam int BN  = 3;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int BW = N + 1;
`else
  localparam int BW = N;
`endif
  localparam int T_SINGLE = ADN + BW + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid_in = 1'b0, wren = 1'b0, burst_en = 1'b0, addr_in = 1'b0, data_in = 1'b0, ready_in = 1'b0;
  logic ready_a, valid_out_a, data_out_a, done_a, err_a;
  logic ready_b, valid_out_b, data_out_b, done_b, err_b;
  logic sel_big = 1'b0;
  logic ready_m, valid_out_m, data_out_m, done_m, err_m;

  assign ready_m     = sel_big ? ready_b     : ready_a;
  assign valid_out_m = sel_big ? valid_out_b : valid_out_a;
  assign data_out_m  = sel_big ? data_out_b  : data_out_a;
  assign done_m      = sel_big ? done_b      : done_a;
  assign err_m       = sel_big ? err_b       : err_a;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  logic [N-1:0] wdat [0:7];
  logic [N-1:0] rdat [0:7];
`ifdef SERIAL_SLAVE_PARITY_EN
  logic rpar [0:7];
`endif

  serial_burst_slave #(.N(N), .ADN(ADN), .MEM_DEPTH(2048), .BN(BN)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .wren(wren), .burst_en(burst_en),
    .addr_in(addr_in), .data_in(data_in), .ready_in(ready_in), .ready(ready_a),
    .valid_out(valid_out_a), .data_out(data_out_a), .done(done_a), .err(err_a));

  serial_burst_slave #(.N(N), .ADN(ADN), .MEM_DEPTH(4096), .BN(BN)) u_dut_big (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .wren(wren), .burst_en(burst_en),
    .addr_in(addr_in), .data_in(data_in), .ready_in(ready_in), .ready(ready_b),
    .valid_out(valid_out_b), .data_out(data_out_b), .done(done_b), .err(err_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_header(input logic is_wr, input logic [ADN-1:0] addr, input logic burst,
                             input logic [BN-1:0] len);
    t0 = cyc;
    valid_in = 1'b1;
    wren     = is_wr;
    burst_en = burst;
    for (int i = ADN - 1; i >= 0; i--) begin
      addr_in = addr[i];
      tick();
      wren     = ~is_wr;
      burst_en = ~burst;
    end
    if (burst) begin
      for (int i = BN - 1; i >= 0; i--) begin
        addr_in = len[i];
        tick();
      end
    end
    addr_in = 1'b0;
  endtask

  task automatic wait_done(output int done_at, output logic err_at);
    done_at = -1;
    err_at  = 1'bx;
    for (int g = 0; g < 8; g++) begin
      if (done_m === 1'b1) begin
        done_at = cyc - t0;
        err_at  = err_m;
        break;
      end
      tick();
    end
    valid_in = 1'b0;
    ready_in = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [ADN-1:0] addr, input logic burst, input logic [BN-1:0] len,
                          input logic bad_par, output int done_at, output logic err_at);
    logic [BW-1:0] bits;
    send_header(1'b1, addr, burst, len);
    for (int b = 0; b <= int'(len); b++) begin
`ifdef SERIAL_SLAVE_PARITY_EN
      bits = {wdat[b], (^wdat[b]) ^ bad_par};
`else
      bits = wdat[b];
`endif
      valid_in = 1'b1;
      for (int k = BW - 1; k >= 0; k--) begin
        data_in = bits[k];
        tick();
      end
      data_in = 1'b1;
      tick();
    end
    wait_done(done_at, err_at);
    $display("write addr=%03h burst=%0b len=%0d badpar=%0b done@%0d err=%b", addr, burst, len, bad_par, done_at, err_at);
  endtask

  task automatic do_read(input logic [ADN-1:0] addr, input logic burst, input logic [BN-1:0] len,
                         input logic stall, output int done_at, output logic err_at, output int hold_bad);
    logic [BW-1:0] bits;
    logic held;
    int k;
    int p;
    hold_bad = 0;
    held = 1'b0;
    send_header(1'b0, addr, burst, len);
    valid_in = 1'b1;
    data_in  = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      ready_in = 1'b1;
      if (valid_out_m !== 1'b0) hold_bad++;
      tick();
      bits = '0;
      k = 0;
      p = 0;
      while (k < BW && p < 100) begin
        ready_in = !stall || (p % 3 == 0);
        if (valid_out_m !== 1'b1) hold_bad++;
        if (ready_in) begin
          bits = {bits[BW-2:0], data_out_m};
          k++;
        end else begin
          held = data_out_m;
        end
        p++;
        tick();
        if (!ready_in && data_out_m !== held) hold_bad++;
      end
      if (k < BW) hold_bad++;
      rdat[b] = bits[BW-1 -: N];
`ifdef SERIAL_SLAVE_PARITY_EN
      rpar[b] = bits[0];
`endif
    end
    wait_done(done_at, err_at);
    $display("read  addr=%03h burst=%0b len=%0d stall=%0b data0=%02h done@%0d err=%b holdbad=%0d",
             addr, burst, len, stall, rdat[0], done_at, err_at, hold_bad);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ready_m, valid_out_m, data_out_m, done_m, err_m} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 00000", {ready_m, valid_out_m, data_out_m, done_m, err_m});
    end
    reset_n = 1'b1;
    #2;
    n_vec++;
    if (ready_m !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b required 0", ready_m); end
    tick();
    n_vec++;
    if (ready_m !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b required 1", ready_m); end
  endtask

  task automatic test_reset_mid_wdata();
    int d; int hb; logic e;
    wdat[0] = 8'h3C;
    do_write(12'h010, 1'b0, 3'd0, 1'b0, d, e);
    n_vec++;
    if (d !== T_SINGLE || e !== 1'b0) begin n_err++; $display("FAIL prewrite: done@%0d err=%b required done@%0d err=0", d, e, T_SINGLE); end
    send_header(1'b1, 12'h010, 1'b0, 3'd0);
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 1'b1;
      tick();
    end
    reset_n  = 1'b0;
    valid_in = 1'b0;
    #1;
    n_vec++;
    if ({ready_m, valid_out_m, data_out_m, done_m, err_m} !== 5'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b required 00000", {ready_m, valid_out_m, data_out_m, done_m, err_m});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (ready_m !== 1'b1) begin n_err++; $display("FAIL midreset_idle: ready got %b required 1", ready_m); end
    do_read(12'h010, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h3C || d !== T_SINGLE) begin
      n_err++;
      $display("FAIL midreset_word: got %02h done@%0d required 3c done@%0d", rdat[0], d, T_SINGLE);
    end
  endtask

  task automatic test_write_read();
    int d; int hb; logic e;
    wdat[0] = 8'hA5;
    do_write(12'h010, 1'b0, 3'd0, 1'b0, d, e);
    n_vec++;
    if (d !== T_SINGLE || e !== 1'b0) begin n_err++; $display("FAIL wr_a5_resp: done@%0d err=%b required done@%0d err=0", d, e, T_SINGLE); end
    do_read(12'h010, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'hA5) begin n_err++; $display("FAIL rd_a5_data: got %02h required a5", rdat[0]); end
    n_vec++;
    if (d !== T_SINGLE || e !== 1'b0 || hb !== 0) begin
      n_err++;
      $display("FAIL rd_a5_resp: done@%0d err=%b holdbad=%0d required done@%0d err=0 holdbad=0", d, e, hb, T_SINGLE);
    end
`ifdef SERIAL_SLAVE_PARITY_EN
    n_vec++;
    if (rpar[0] !== 1'b0) begin n_err++; $display("FAIL rd_a5_parity: got %b required 0", rpar[0]); end
`endif
  endtask

  task automatic test_burst_wrap();
    int d; int hb; logic e;
    logic [N-1:0] exp_w [0:3];
    exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
    for (int i = 0; i < 4; i++) wdat[i] = exp_w[i];
    sel_big = 1'b1;
    do_write(12'hFFE, 1'b1, 3'd3, 1'b0, d, e);
    n_vec++;
    if (d !== ADN + BN + 4 * (BW + 1) || e !== 1'b0) begin
      n_err++;
      $display("FAIL burst_wr_resp: done@%0d err=%b required done@%0d err=0", d, e, ADN + BN + 4 * (BW + 1));
    end
    do_read(12'hFFE, 1'b1, 3'd3, 1'b0, d, e, hb);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rdat[i] !== exp_w[i]) begin n_err++; $display("FAIL burst_rd_beat%0d: got %02h required %02h", i, rdat[i], exp_w[i]); end
    end
    n_vec++;
    if (d !== ADN + BN + 4 * (BW + 1) || e !== 1'b0 || hb !== 0) begin
      n_err++;
      $display("FAIL burst_rd_resp: done@%0d err=%b holdbad=%0d required done@%0d err=0 holdbad=0", d, e, hb, ADN + BN + 4 * (BW + 1));
    end
    sel_big = 1'b0;
    do_read(12'h000, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h33 || e !== 1'b0) begin n_err++; $display("FAIL wrap_small_000: got %02h err=%b required 33 err=0", rdat[0], e); end
  endtask

  task automatic test_out_of_range();
    int d; int hb; logic e;
    sel_big = 1'b0;
    do_read(12'h900, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h00 || e !== 1'b1 || d !== T_SINGLE) begin
      n_err++;
      $display("FAIL oor_read: got %02h err=%b done@%0d required 00 err=1 done@%0d", rdat[0], e, d, T_SINGLE);
    end
    wdat[0] = 8'h77;
    do_write(12'h900, 1'b0, 3'd0, 1'b0, d, e);
    n_vec++;
    if (e !== 1'b1 || d !== T_SINGLE) begin n_err++; $display("FAIL oor_write: err=%b done@%0d required err=1 done@%0d", e, d, T_SINGLE); end
    wdat[0] = 8'h5E;
    do_write(12'h7FF, 1'b0, 3'd0, 1'b0, d, e);
    do_read(12'h7FF, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h5E || e !== 1'b0) begin n_err++; $display("FAIL top_word_7ff: got %02h err=%b required 5e err=0", rdat[0], e); end
  endtask

  task automatic test_backpressure();
    int d; int hb; logic e;
    do_read(12'h010, 1'b0, 3'd0, 1'b1, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'hA5 || hb !== 0) begin n_err++; $display("FAIL bp_data: got %02h holdbad=%0d required a5 holdbad=0", rdat[0], hb); end
    n_vec++;
    if (d !== T_SINGLE + 2 * (BW - 1) || e !== 1'b0) begin
      n_err++;
      $display("FAIL bp_done: done@%0d err=%b required done@%0d err=0", d, e, T_SINGLE + 2 * (BW - 1));
    end
  endtask

  task automatic test_back_to_back();
    int d; int hb; int t_w; logic e;
    wdat[0] = 8'h81;
    do_write(12'h030, 1'b0, 3'd0, 1'b0, d, e);
    t_w = t0;
    do_read(12'h030, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (t0 - t_w !== T_SINGLE + 1 || rdat[0] !== 8'h81) begin
      n_err++;
      $display("FAIL b2b: restart@%0d data=%02h required restart@%0d data=81", t0 - t_w, rdat[0], T_SINGLE + 1);
    end
  endtask

`ifdef SERIAL_SLAVE_PARITY_EN
  task automatic test_parity();
    int d; int hb; logic e;
    wdat[0] = 8'h5A;
    do_write(12'h020, 1'b0, 3'd0, 1'b0, d, e);
    wdat[0] = 8'h3C;
    do_write(12'h020, 1'b0, 3'd0, 1'b1, d, e);
    n_vec++;
    if (e !== 1'b1) begin n_err++; $display("FAIL par_bad_err: got %b required 1", e); end
    do_read(12'h020, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h5A) begin n_err++; $display("FAIL par_bad_nowrite: got %02h required 5a", rdat[0]); end
    do_write(12'h020, 1'b0, 3'd0, 1'b0, d, e);
    n_vec++;
    if (e !== 1'b0) begin n_err++; $display("FAIL par_good_err: got %b required 0", e); end
    do_read(12'h020, 1'b0, 3'd0, 1'b0, d, e, hb);
    n_vec++;
    if (rdat[0] !== 8'h3C || rpar[0] !== 1'b0) begin
      n_err++;
      $display("FAIL par_good_read: got %02h par=%b required 3c par=0", rdat[0], rpar[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_wdata();
    test_write_read();
    test_burst_wrap();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
`ifdef SERIAL_SLAVE_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 500000");
    $fatal(1, "watchdog");
  end

endmodule
